// File: rtl/nios_system_cpu_div_cell_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package nios_system_cpu_div_cell_pkg;

  localparam int DIV_DATA_W  = 32;
  localparam int DIV_LATENCY = DIV_DATA_W + 3;
  localparam int CNT_W       = $clog2(DIV_DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_t;

endpackage

`default_nettype wire

// File: rtl/nios_system_cpu_div_cell_step.sv
// One combinational restoring-division step: shift {rem,quo} left and try to subtract.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module nios_system_cpu_div_cell_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0] partial;
  logic [DATA_W:0] trial;

  // The shifted remainder can exceed DATA_W bits for one step, so the trial runs one bit wider.
  assign partial  = {rem, quo[DATA_W-1]};
  assign trial    = partial - {1'b0, divisor};
  assign rem_next = trial[DATA_W] ? partial[DATA_W-1:0] : trial[DATA_W-1:0];
  assign quo_next = {quo[DATA_W-2:0], ~trial[DATA_W]};

endmodule

`default_nettype wire

// File: rtl/nios_system_cpu_div_cell.sv
// Sequential signed/unsigned divider with start/done handshake and fixed DATA_W+3 latency.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module nios_system_cpu_div_cell
  import nios_system_cpu_div_cell_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              A_div_start,
  input  logic              A_div_signed,
  input  logic [DATA_W-1:0] A_div_src1,
  input  logic [DATA_W-1:0] A_div_src2,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quotient,
  output logic [DATA_W-1:0] A_div_remainder
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t        state;
  div_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic              sgn_q;
  logic [DATA_W-1:0] divisor;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic              neg_q;
  logic              neg_r;
  logic              dz;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;

  assign abs1 = (sgn_q & src1_q[DATA_W-1]) ? -src1_q : src1_q;
  assign abs2 = (sgn_q & src2_q[DATA_W-1]) ? -src2_q : src2_q;

  nios_system_cpu_div_cell_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (A_div_start) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (cnt == LAST_CNT) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt             <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      sgn_q           <= 1'b0;
      divisor         <= '0;
      rem             <= '0;
      quo             <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      dz              <= 1'b0;
      A_div_busy      <= 1'b0;
      A_div_done      <= 1'b0;
      A_div_quotient  <= '0;
      A_div_remainder <= '0;
    end else begin
      A_div_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (A_div_start) begin
            src1_q     <= A_div_src1;
            src2_q     <= A_div_src2;
            sgn_q      <= A_div_signed;
            A_div_busy <= 1'b1;
          end
        end
        PREP: begin
          divisor <= abs2;
          quo     <= abs1;
          rem     <= '0;
          neg_q   <= sgn_q & (src1_q[DATA_W-1] ^ src2_q[DATA_W-1]);
          neg_r   <= sgn_q & src1_q[DATA_W-1];
          dz      <= (src2_q == '0);
          cnt     <= '0;
        end
        ITER: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          // Divide-by-zero overrides the sign fix-up in both signed and unsigned modes.
          A_div_quotient  <= dz ? '1 : (neg_q ? -quo : quo);
          A_div_remainder <= dz ? src1_q : (neg_r ? -rem : rem);
          A_div_busy      <= 1'b0;
          A_div_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios_system_cpu_div_cell.sv
// Directed and model-checked bench for the sequential divider.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_nios_system_cpu_div_cell;
  import nios_system_cpu_div_cell_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;

  nios_system_cpu_div_cell #(.DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .A_div_start     (start),
    .A_div_signed    (sgn),
    .A_div_src1      (src1),
    .A_div_src2      (src2),
    .A_div_busy      (busy),
    .A_div_done      (done),
    .A_div_quotient  (quotient),
    .A_div_remainder (remainder)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepted at the next edge (k); returns at #1 after the edge where done is seen.
  // lat = edges after k until done; done lies in cycle k+DIV_LATENCY, i.e. lat = DIV_LATENCY-1.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r,
                        output int lat, output int bcnt);
    start = 1'b1; sgn = s; src1 = a; src2 = b;
    @(posedge clk); #1;
    start = 1'b0; sgn = ~s; src1 = ~a; src2 = b ^ 32'h5a5a_a5a5;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    q = quotient; r = remainder;
  endtask

  task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] q, r, eq, er;
    int lat, bcnt, dcnt;

    vecs[0] = '{1'b0, 32'd100,         32'd7,           32'd14,          32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   32'd1};
    vecs[3] = '{1'b0, 32'h1234_5678,   32'd0,           32'hFFFF_FFFF,   32'h1234_5678};
    vecs[4] = '{1'b1, 32'h1234_5678,   32'd0,           32'hFFFF_FFFF,   32'h1234_5678};
    vecs[5] = '{1'b1, 32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   32'd0};
    vecs[6] = '{1'b0, 32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           32'h8000_0000};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF,   32'd1,           32'hFFFF_FFFF,   32'd0};
    vecs[8] = '{1'b1, 32'hFFFF_FF9C,   32'hFFFF_FFF9,   32'd14,          32'hFFFF_FFFE};
    vecs[9] = '{1'b0, 32'd5,           32'd9,           32'd0,           32'd5};

    reset = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_quo", quotient, 0);
    check_eq("rst_rem", remainder, 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, q, r, lat, bcnt);
      check_eq($sformatf("v%0d_lat", i), lat, DIV_LATENCY - 1);
      check_eq($sformatf("v%0d_busycyc", i), bcnt, DIV_LATENCY - 1);
      check_eq($sformatf("v%0d_busy_at_done", i), busy, 0);
      check_eq($sformatf("v%0d_quo", i), q, vecs[i].q);
      check_eq($sformatf("v%0d_rem", i), r, vecs[i].r);
      @(posedge clk); #1;
      check_eq($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Start while busy is ignored.
    start = 1'b1; sgn = 1'b0; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        start = 1'b1; src1 = 32'd200; src2 = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check_eq("busy_start_lat", lat, DIV_LATENCY - 1);
    check_eq("busy_start_quo", quotient, 32'd14);
    check_eq("busy_start_rem", remainder, 32'd2);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check_eq("busy_start_extra_done", dcnt, 0);

    // Back-to-back issue in the done cycle.
    run_op(1'b0, 32'd1000, 32'd10, q, r, lat, bcnt);
    check_eq("b2b_first_quo", q, 32'd100);
    run_op(1'b1, 32'hFFFF_FC18, 32'd3, q, r, lat, bcnt);
    check_eq("b2b_second_lat", lat, DIV_LATENCY - 1);
    check_eq("b2b_second_quo", q, 32'hFFFF_FEB3);
    check_eq("b2b_second_rem", r, 32'hFFFF_FFFF);

    // Reset mid-iteration discards the operation.
    start = 1'b1; sgn = 1'b0; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_quo", quotient, 0);
    check_eq("midrst_rem", remainder, 0);
    #1 reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check_eq("midrst_no_done", dcnt, 0);
    run_op(1'b0, 32'd100, 32'd7, q, r, lat, bcnt);
    check_eq("post_rst_lat", lat, DIV_LATENCY - 1);
    check_eq("post_rst_quo", q, 32'd14);
    check_eq("post_rst_rem", r, 32'd2);

    // Model-checked random pairs, biased toward small and zero divisors.
    for (int n = 0; n < 200; n++) begin
      logic        s;
      logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 20);
        2:       b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      model(s, a, b, eq, er);
      run_op(s, a, b, q, r, lat, bcnt);
      check_eq($sformatf("rnd%0d_lat", n), lat, DIV_LATENCY - 1);
      check_eq($sformatf("rnd%0d_quo s=%0d a=%0h b=%0h", n, s, a, b), q, eq);
      check_eq($sformatf("rnd%0d_rem s=%0d a=%0h b=%0h", n, s, a, b), r, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
